// File: rtl/imem_loader.sv
// Instruction memory with a boot-time stream loader.
//
// A framed byte stream is written into an internal word RAM. The frame is a
// 2-byte big-endian word count N, then N*4 payload bytes (each word MSB
// first), then one checksum byte (XOR of the payload bytes). The core is held
// in reset until a frame with a matching checksum is resident. After that the
// core fetches from the RAM through a combinational path.
//
// Ports:
//   clk_i           system clock, all state updates on posedge
//   rst             synchronous active-high reset
//   in_byte_i       loader stream byte
//   in_valid_i      in_byte_i is valid this cycle
//   in_ready_o      byte is accepted when in_valid_i && in_ready_o at posedge
//   pc_i            core fetch byte address
//   ir_o            fetched instruction word (0 when not fetchable)
//   core_rst_o      core reset, high until a verified image is loaded
//   load_done_o     image loaded and checksum matched
//   err_o           load failed (oversize length or bad checksum)
//   words_loaded_o  number of words written so far
module imem_loader #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic        clk_i,
   input  logic        rst,
   input  logic [7:0]  in_byte_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] pc_i,
   output logic [31:0] ir_o,
   output logic        core_rst_o,
   output logic        load_done_o,
   output logic        err_o,
   output logic [15:0] words_loaded_o
);

   typedef enum logic [2:0] {
      StLenHi,
      StLenLo,
      StData,
      StCsum,
      StDone,
      StError
   } state_e;

   // 17 bits so that DEPTH = 65536 compares correctly against a 16-bit length.
   localparam logic [16:0] DepthW = 17'(DEPTH);

   state_e      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [23:0] asm_q, asm_d;
   logic [7:0]  csum_q, csum_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [15:0] words_q, words_d;
   logic        in_ready_q, core_rst_q, load_done_q, err_q;

   logic        accept;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [15:0] len_full;

   logic [31:0] mem_q [DEPTH];

   assign accept   = in_valid_i && in_ready_q;
   assign len_full = {len_q[15:8], in_byte_i};

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      asm_d      = asm_q;
      csum_d     = csum_q;
      byte_cnt_d = byte_cnt_q;
      words_d    = words_q;
      mem_we     = 1'b0;
      mem_wdata  = {asm_q, in_byte_i};
      if (accept) begin
         unique case (state_q)
            StLenHi: begin
               len_d[15:8] = in_byte_i;
               state_d     = StLenLo;
            end
            StLenLo: begin
               len_d[7:0] = in_byte_i;
               if ({1'b0, len_full} > DepthW) begin
                  state_d = StError;
               end else if (len_full == 16'd0) begin
                  state_d = StCsum;
               end else begin
                  state_d = StData;
               end
            end
            StData: begin
               asm_d      = {asm_q[15:0], in_byte_i};
               csum_d     = csum_q ^ in_byte_i;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  mem_we  = 1'b1;
                  words_d = words_q + 16'd1;
                  if (words_d == len_q) begin
                     state_d = StCsum;
                  end
               end
            end
            StCsum: begin
               state_d = (in_byte_i == csum_q) ? StDone : StError;
            end
            // Bytes in ERROR are swallowed; DONE never accepts.
            StDone, StError: state_d = state_q;
            default:         state_d = StError;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         state_q     <= StLenHi;
         len_q       <= 16'd0;
         asm_q       <= 24'd0;
         csum_q      <= 8'd0;
         byte_cnt_q  <= 2'd0;
         words_q     <= 16'd0;
         in_ready_q  <= 1'b1;
         core_rst_q  <= 1'b1;
         load_done_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         asm_q       <= asm_d;
         csum_q      <= csum_d;
         byte_cnt_q  <= byte_cnt_d;
         words_q     <= words_d;
         // Outputs follow the next state so they are flops, not state decode.
         in_ready_q  <= (state_d != StDone);
         core_rst_q  <= (state_d != StDone);
         load_done_q <= (state_d == StDone);
         err_q       <= (state_d == StError);
      end
   end

   // RAM is deliberately not reset; words_loaded gates visibility instead.
   always_ff @(posedge clk_i) begin
      if (mem_we && !rst) begin
         mem_q[words_q[AW-1:0]] <= mem_wdata;
      end
   end

   // Combinational fetch path.
   logic [AW-1:0] widx;
   logic          pc_in_range;
   logic          unused_pc_lsb;

   assign widx          = pc_i[AW+1:2];
   assign pc_in_range   = (pc_i[31:AW+2] == '0);
   assign unused_pc_lsb = ^pc_i[1:0];

   always_comb begin
      ir_o = 32'h0000_0000;
      if (load_done_q && pc_in_range && (16'(widx) < words_q)) begin
         ir_o = mem_q[widx];
      end
   end

   assign in_ready_o     = in_ready_q;
   assign core_rst_o     = core_rst_q;
   assign load_done_o    = load_done_q;
   assign err_o          = err_q;
   assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

   logic        clk_i = 1'b0;
   logic        rst;
   logic [7:0]  in_byte_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] pc_i;
   logic [31:0] ir_o;
   logic        core_rst_o;
   logic        load_done_o;
   logic        err_o;
   logic [15:0] words_loaded_o;

   int checks   = 0;
   int failures = 0;

   // Nominal frame: N=2, 0x12345678, 0xDEADBEEF, checksum.
   // XOR of the eight payload bytes works out to 0x2A.
   logic [7:0] nom [0:10];

   imem_loader #(
      .DEPTH(256),
      .AW   (8)
   ) dut (
      .clk_i         (clk_i),
      .rst           (rst),
      .in_byte_i     (in_byte_i),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .pc_i          (pc_i),
      .ir_o          (ir_o),
      .core_rst_o    (core_rst_o),
      .load_done_o   (load_done_o),
      .err_o         (err_o),
      .words_loaded_o(words_loaded_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      in_valid_i = 1'b0;
      in_byte_i  = 8'h00;
      repeat (2) @(posedge clk_i);
      #1;
      rst = 1'b0;
   endtask

   // Drive one byte, wait (bounded) for ready, hold for one accepting edge.
   task automatic send_byte(input logic [7:0] b, input bit throttle);
      int n;
      if (throttle) begin
         in_valid_i = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk_i);
            #1;
         end
      end
      in_byte_i  = b;
      in_valid_i = 1'b1;
      n          = 0;
      while (!in_ready_o && n < 20) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      if (n == 20) check_eq("ready_timeout", 32'(in_ready_o), 32'd1);
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
   endtask

   task automatic send_nominal(input bit throttle, input logic [7:0] csum);
      for (int i = 0; i < 10; i++) send_byte(nom[i], throttle);
      send_byte(csum, throttle);
   endtask

   task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] exp);
      pc_i = pc;
      #1;
      check_eq(tag, ir_o, exp);
   endtask

   task automatic check_nominal_result(input string pfx);
      check_eq({pfx, "_load_done"}, 32'(load_done_o), 32'd1);
      check_eq({pfx, "_core_rst"}, 32'(core_rst_o), 32'd0);
      check_eq({pfx, "_err"}, 32'(err_o), 32'd0);
      check_eq({pfx, "_in_ready"}, 32'(in_ready_o), 32'd0);
      check_eq({pfx, "_words"}, 32'(words_loaded_o), 32'd2);
      fetch({pfx, "_ir_pc0"}, 32'h0, 32'h1234_5678);
      fetch({pfx, "_ir_pc4"}, 32'h4, 32'hDEAD_BEEF);
      fetch({pfx, "_ir_pc8"}, 32'h8, 32'h0);
      fetch({pfx, "_ir_pc6"}, 32'h6, 32'hDEAD_BEEF);
   endtask

   initial begin
      nom = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
              8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};
      pc_i = 32'h0;

      // Reset state
      do_reset();
      check_eq("rst_in_ready", 32'(in_ready_o), 32'd1);
      check_eq("rst_core_rst", 32'(core_rst_o), 32'd1);
      check_eq("rst_load_done", 32'(load_done_o), 32'd0);
      check_eq("rst_err", 32'(err_o), 32'd0);
      check_eq("rst_words", 32'(words_loaded_o), 32'd0);
      fetch("rst_ir", 32'h0, 32'h0);

      // Nominal load, core stays in reset until the checksum byte lands
      for (int i = 0; i < 10; i++) send_byte(nom[i], 1'b0);
      check_eq("nom_pre_csum_core_rst", 32'(core_rst_o), 32'd1);
      check_eq("nom_pre_csum_words", 32'(words_loaded_o), 32'd2);
      fetch("nom_pre_csum_ir", 32'h0, 32'h0);
      send_byte(8'h2A, 1'b0);
      check_nominal_result("nom");

      // Out-of-range fetches after a good load
      fetch("oor_word256", 32'h0000_0400, 32'h0);
      fetch("oor_high", 32'h8000_0000, 32'h0);
      fetch("oor_word255", 32'h0000_03FC, 32'h0);

      // Bad checksum
      do_reset();
      send_nominal(1'b0, 8'h45);
      check_eq("bad_err", 32'(err_o), 32'd1);
      check_eq("bad_core_rst", 32'(core_rst_o), 32'd1);
      check_eq("bad_in_ready", 32'(in_ready_o), 32'd1);
      check_eq("bad_load_done", 32'(load_done_o), 32'd0);
      fetch("bad_ir_pc0", 32'h0, 32'h0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      check_eq("bad_after_err", 32'(err_o), 32'd1);
      check_eq("bad_after_load_done", 32'(load_done_o), 32'd0);
      check_eq("bad_after_words", 32'(words_loaded_o), 32'd2);

      // Oversize length 257 errors on the LEN_LO byte
      do_reset();
      send_byte(8'h01, 1'b0);
      check_eq("ovs_err_after_hi", 32'(err_o), 32'd0);
      send_byte(8'h01, 1'b0);
      check_eq("ovs_err", 32'(err_o), 32'd1);
      check_eq("ovs_words", 32'(words_loaded_o), 32'd0);
      check_eq("ovs_core_rst", 32'(core_rst_o), 32'd1);

      // Zero-length frame
      do_reset();
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      check_eq("zero_load_done", 32'(load_done_o), 32'd1);
      check_eq("zero_core_rst", 32'(core_rst_o), 32'd0);
      check_eq("zero_words", 32'(words_loaded_o), 32'd0);
      fetch("zero_ir_pc0", 32'h0, 32'h0);
      fetch("zero_ir_pc4", 32'h4, 32'h0);

      // Throttled nominal frame
      do_reset();
      send_nominal(1'b1, 8'h2A);
      check_nominal_result("thr");

      // Reset mid-load, with a byte offered during the reset cycle
      do_reset();
      for (int i = 0; i < 6; i++) send_byte(nom[i], 1'b0);
      check_eq("mid_words_before", 32'(words_loaded_o), 32'd1);
      rst        = 1'b1;
      in_valid_i = 1'b1;
      in_byte_i  = 8'hAA;
      @(posedge clk_i);
      #1;
      rst        = 1'b0;
      in_valid_i = 1'b0;
      check_eq("mid_words_rst", 32'(words_loaded_o), 32'd0);
      check_eq("mid_core_rst", 32'(core_rst_o), 32'd1);
      send_nominal(1'b0, 8'h2A);
      check_nominal_result("mid");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
